// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and
// the clocks-per-bit helper also used by the transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    function automatic int ticks_per_bit(
        input int clk_freq,
        input int baud_rate
    );
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Reset value is a parameter so idle-high and idle-low lines both fit.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, one-cycle valid strobe with error flags.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity checking.
module uart_rx #(
    parameter int CLK_FREQ  = 27000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_error,
    output logic       parity_error,
    output logic       busy
);

    import uart_pkg::*;

    localparam int BIT_TICKS  = ticks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam logic [15:0] BIT_LAST  = 16'(BIT_TICKS - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_TICKS - 1);
    localparam logic [2:0]  IDX_LAST  = 3'(DATA_BITS - 1);

    rx_state_t   r_state;
    rx_state_t   w_state_nxt;
    logic        w_rx_s;
    logic        r_prev;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_ferr;
    logic        w_tick_last;
    logic        w_sample;
`ifdef UART_RX_PARITY_EN
    logic        r_par;
    logic        r_perr;
`endif

    uart_sync #(
        .RST_VAL(1'b1)
    ) u_sync (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_d    (rx),
        .o_q    (w_rx_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tick_last = (r_state == S_START) ? (r_cnt == HALF_LAST)
                                           : (r_cnt == BIT_LAST);
        w_sample    = w_tick_last && (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                // Edge, not level: a held-low break cannot retrigger
                if (r_prev && !w_rx_s) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_tick_last) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_tick_last && r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_tick_last) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_tick_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_prev  <= 1'b1;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_prev  <= w_rx_s;
            r_valid <= 1'b0;
            r_cnt   <= (r_state == S_IDLE || w_tick_last) ? '0
                                                          : r_cnt + 16'd1;
            if (w_sample) begin
                unique case (r_state)
                    S_START: begin
                        r_idx <= '0;
`ifdef UART_RX_PARITY_EN
                        r_par <= 1'b0;
`endif
                    end
                    S_DATA: begin
                        r_shift[r_idx] <= w_rx_s;
                        r_idx          <= r_idx + 3'd1;
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: r_par <= w_rx_s ^ (^r_shift);
`endif
                    S_STOP: begin
                        r_valid <= 1'b1;
                        r_data  <= r_shift;
                        r_ferr  <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                        r_perr  <= r_par;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data        = r_data;
    assign valid       = r_valid;
    assign frame_error = r_ferr;
    assign busy        = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error = r_perr;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (234 clocks per bit).
module tb_uart_rx;

    localparam int BT = 234;
    localparam int HT = 117;
`ifdef UART_RX_PARITY_EN
    localparam bit USE_PAR = 1'b1;
    localparam int NBITS   = 11;
`else
    localparam bit USE_PAR = 1'b0;
    localparam int NBITS   = 10;
`endif
    // pin fall -> valid: 2 sync + half bit + remaining bits + 1
    localparam int VALID_OFS = 2 + HT + (NBITS - 1) * BT + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_error;
    logic       parity_error;
    logic       busy;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] v_data[$];
    logic       v_fe[$];
    logic       v_pe[$];
    int         v_cyc[$];

    uart_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .frame_error (frame_error),
        .parity_error(parity_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            v_data.push_back(data);
            v_fe.push_back(frame_error);
            v_pe.push_back(parity_error);
            v_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic epar(input logic [7:0] b);
        return ^b;
    endfunction

    task automatic clear_q();
        v_data.delete();
        v_fe.delete();
        v_pe.delete();
        v_cyc.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // returns at the negedge inside cycle n
    task automatic wait_until(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    // call aligned #1 after a posedge; leaves rx at the stop value
    task automatic send_frame(input logic [7:0] b, input logic pbit,
                              input logic stop, output int p);
        rx = 1'b0;
        p  = cyc;
        wait_cycles(BT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(BT);
        end
        if (USE_PAR) begin
            rx = pbit;
            wait_cycles(BT);
        end
        rx = stop;
        wait_cycles(BT);
    endtask

    initial begin
        int p0;
        int pb[3];
        int pr;
        logic [7:0] bb[3];

        rst_n = 1'b0;
        rx    = 1'b1;
        wait_cycles(4);
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wait_cycles(3);
        check("idle_fe", 32'(frame_error), 32'd0);
        check("idle_pe", 32'(parity_error), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // single 0x55 frame with exact timing
        clear_q();
        p0 = cyc;
        fork
            send_frame(8'h55, epar(8'h55), 1'b1, pr);
            begin
                wait_until(p0 + 2);
                check("t55_busy_pre", 32'(busy), 32'd0);
                wait_until(p0 + 3);
                check("t55_busy_rise", 32'(busy), 32'd1);
                wait_until(p0 + VALID_OFS - 1);
                check("t55_valid_pre", 32'(valid), 32'd0);
                check("t55_busy_pre_v", 32'(busy), 32'd1);
                wait_until(p0 + VALID_OFS);
                check("t55_valid", 32'(valid), 32'd1);
                check("t55_busy_fall", 32'(busy), 32'd0);
                wait_until(p0 + VALID_OFS + 1);
                check("t55_valid_post", 32'(valid), 32'd0);
            end
        join
        wait_cycles(BT);
        check("t55_count", 32'(v_data.size()), 32'd1);
        if (v_data.size() > 0) begin
            check("t55_data", 32'(v_data[0]), 32'h55);
            check("t55_fe", 32'(v_fe[0]), 32'd0);
            check("t55_pe", 32'(v_pe[0]), 32'd0);
            check("t55_cyc", 32'(v_cyc[0]), 32'(pr + VALID_OFS));
        end

        // back-to-back frames, no idle gap
        clear_q();
        bb[0] = 8'h00;
        bb[1] = 8'hFF;
        bb[2] = 8'hA5;
        for (int i = 0; i < 3; i++)
            send_frame(bb[i], epar(bb[i]), 1'b1, pb[i]);
        wait_cycles(2 * BT);
        check("b2b_count", 32'(v_data.size()), 32'd3);
        if (v_data.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("b2b_data%0d", i), 32'(v_data[i]),
                      32'(bb[i]));
                check($sformatf("b2b_cyc%0d", i), 32'(v_cyc[i]),
                      32'(pb[i] + VALID_OFS));
            end
        end

        // 50-cycle glitch is rejected at the start-bit sample
        clear_q();
        rx = 1'b0;
        p0 = cyc;
        wait_until(p0 + 3);
        check("gl_busy_rise", 32'(busy), 32'd1);
        wait_until(p0 + 50);
        rx = 1'b1;
        wait_until(p0 + 2 + HT);
        check("gl_busy_start", 32'(busy), 32'd1);
        wait_until(p0 + 2 + HT + 1);
        check("gl_busy_fall", 32'(busy), 32'd0);
        wait_cycles(3 * BT);
        check("gl_count", 32'(v_data.size()), 32'd0);

        // stop bit low, then break held for 20 bit times
        clear_q();
        send_frame(8'h3C, epar(8'h3C), 1'b0, pr);
        wait_cycles(10 * BT);
        check("fe_busy_break", 32'(busy), 32'd0);
        wait_cycles(10 * BT);
        rx = 1'b1;
        wait_cycles(3 * BT);
        check("fe_count", 32'(v_data.size()), 32'd1);
        if (v_data.size() > 0) begin
            check("fe_data", 32'(v_data[0]), 32'h3C);
            check("fe_flag", 32'(v_fe[0]), 32'd1);
            check("fe_cyc", 32'(v_cyc[0]), 32'(pr + VALID_OFS));
        end
        check("fe_hold", 32'(frame_error), 32'd1);

        // reset pulse during data bit 4 of 0xF1 (bits 4..7 high)
        clear_q();
        fork
            send_frame(8'hF1, epar(8'hF1), 1'b1, pr);
            begin
                wait_cycles(5 * BT + 100);
                rst_n = 1'b0;
                wait_cycles(1);
                rst_n = 1'b1;
                @(negedge clk);
                check("mr_data", 32'(data), 32'h00);
                check("mr_valid", 32'(valid), 32'd0);
                check("mr_fe", 32'(frame_error), 32'd0);
                check("mr_pe", 32'(parity_error), 32'd0);
                check("mr_busy", 32'(busy), 32'd0);
            end
        join
        wait_cycles(2 * BT);
        check("mr_count", 32'(v_data.size()), 32'd0);
        send_frame(8'h81, epar(8'h81), 1'b1, pr);
        wait_cycles(BT);
        check("mr81_count", 32'(v_data.size()), 32'd1);
        if (v_data.size() > 0) begin
            check("mr81_data", 32'(v_data[0]), 32'h81);
            check("mr81_fe", 32'(v_fe[0]), 32'd0);
        end

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit is 1
        clear_q();
        send_frame(8'h07, 1'b1, 1'b1, pr);
        send_frame(8'h07, 1'b0, 1'b1, pr);
        wait_cycles(BT);
        check("par_count", 32'(v_data.size()), 32'd2);
        if (v_data.size() == 2) begin
            check("par_good", 32'(v_pe[0]), 32'd0);
            check("par_bad", 32'(v_pe[1]), 32'd1);
            check("par_data", 32'(v_data[1]), 32'h07);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1 framing, LSB first; the receive-side counterpart of the board's UART transmitter. Sits between the `uart_rx` board pin and the top-level logic. Delivers each received byte with a one-cycle valid strobe plus framing/parity status. Uses the same `CLK_FREQ`/`BAUD_RATE` parameterisation as the transmitter.

## Interface

- `CLK_FREQ`, 27000000, system clock frequency in Hz
- `BAUD_RATE`, 115200, line bit rate in bits/s

- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `rx`  in  1  asynchronous serial line, idle high
- `data`  out  8  last received byte; holds until next frame completes
- `valid`  out  1  one-cycle strobe: `data`/error flags updated this cycle
- `frame_error`  out  1  stop bit sampled low in last frame; held with `data`
- `parity_error`  out  1  parity mismatch in last frame; held with `data`
- `busy`  out  1  high whenever state is not IDLE

## Operation

- `BIT_TICKS = CLK_FREQ / BAUD_RATE` (integer divide; 234 at defaults); `HALF_TICKS = BIT_TICKS / 2` (117).
- `rx` is passed through a 2-FF synchronizer (reset value 1); internal logic sees only `rx_s`.
- Tick counter: 16 bits wide, saturates never (reset to 0 on every state entry or sample).
- States:
  - IDLE: waits for falling edge on `rx_s` (previous 1, current 0) -> START, counter 0. A held-low line (break) does not retrigger.
  - START: when counter reaches `HALF_TICKS-1`, sample `rx_s`. Sample 1 -> IDLE (glitch rejected, no `valid`). Sample 0 -> DATA, counter 0, bit index 0.
  - DATA: sample at counter `BIT_TICKS-1`; shift sample into bit[index] (LSB first). After index 7 -> PARITY (macro on) or STOP.
  - PARITY: sample at `BIT_TICKS-1`; latch mismatch against even parity of the 8 data bits -> STOP.
  - STOP: sample at `BIT_TICKS-1`; next cycle `valid`=1, `data` = shift register, `frame_error` = ~sample, `parity_error` latched -> IDLE.
- Byte with `frame_error` is still delivered (`valid` pulses).
- Reset mid-frame: state IDLE, frame discarded, no `valid`.
- Reset values: `data`=8'h00, `valid`=0, `frame_error`=0, `parity_error`=0, `busy`=0.

## Timing

- t0 = first cycle `rx_s`=0 (2 cycles after pin falls). Start sample at t0+`HALF_TICKS`; each later sample exactly `BIT_TICKS` cycles after the previous.
- `valid` high in cycle t0 + `HALF_TICKS` + 9·`BIT_TICKS` + 1 (10·`BIT_TICKS` with parity); exactly one cycle wide.
- `busy` rises cycle after t0, falls with `valid`.
- Next falling edge accepted from the cycle after `valid` (mid-stop-bit), so back-to-back frames with one stop bit are received without loss.
- No backpressure: consumer must capture `data` before the next `valid`.

## Configuration

- `UART_RX_PARITY_EN` defined: frame is 8E1; PARITY state present; `parity_error` reflects even-parity check.
- Undefined: 8N1; PARITY state absent; `parity_error` tied 0.

## Structure

- Shared package `uart_pkg`: receiver state encoding (IDLE, START, DATA, PARITY, STOP), `DATA_BITS`=8 constant, function computing ticks per bit from `CLK_FREQ`/`BAUD_RATE` (shared with transmitter).
- One sub-module: `uart_sync` (2-FF synchronizer, parameterised reset value), reusable for `btn1`.

## Test plan

- Defaults, rx sends 8'h55 8N1 at 234 clk/bit -> one `valid` pulse, `data`=8'h55, both errors 0, at t0+117+9·234+1.
- Three back-to-back frames 8'h00, 8'hFF, 8'hA5 with no idle gap -> three `valid` pulses, correct bytes in order.
- rx low for 50 cycles then high (glitch) -> no `valid`, `busy` back to 0 by t0+118.
- Frame 8'h3C with stop bit driven low, then line held low 20 bit-times -> one `valid`, `data`=8'h3C, `frame_error`=1, no further `valid` until line rises and falls again.
- `UART_RX_PARITY_EN`: 8'h07 with parity bit 1 -> `parity_error`=0; with parity bit 0 -> `parity_error`=1.
- `rst_n` low for one cycle during bit 4 of a frame -> no `valid`, all outputs reset values; next clean frame 8'h81 received correctly.
